// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and limits for the Gray counter family.
// gray2bin mirrors the existing Gray-to-binary converter for benches and synchronisers.
package gray_pkg;

  localparam int GRAY_W_MAX = 16;

  // Operands are zero-extended to GRAY_W_MAX; upper zero bits encode to zero.
  function automatic logic [GRAY_W_MAX-1:0] bin2gray(input logic [GRAY_W_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_W_MAX-1:0] gray2bin(input logic [GRAY_W_MAX-1:0] g);
    logic [GRAY_W_MAX-1:0] b;
    b[GRAY_W_MAX-1] = g[GRAY_W_MAX-1];
    for (int i = GRAY_W_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_counter_b2g.sv
// Purely combinational binary-to-Gray encoder, WIDTH bits wide.
module b2g #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_counter.sv
// Registered up/down binary counter publishing its count and Gray encoding.
// Gray is encoded from the next-state value so both outputs leave flops on the same edge.
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = 4,   // 2..GRAY_W_MAX
  parameter int INIT  = 0    // must fit in WIDTH bits
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             wrap
);

  localparam logic [WIDTH-1:0]      INIT_BIN  = WIDTH'(INIT);
  localparam logic [GRAY_W_MAX-1:0] INIT_GFUL = bin2gray(GRAY_W_MAX'(INIT_BIN));
  localparam logic [WIDTH-1:0]      INIT_GRAY = INIT_GFUL[WIDTH-1:0];
  localparam logic [WIDTH-1:0]      MAX_BIN   = '1;

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             wrap_q;
  logic [WIDTH-1:0] next_bin;
  logic [WIDTH-1:0] next_gray;
  logic             next_wrap;

  // load beats en; rst is applied in the register itself and beats both.
  always_comb begin
    next_bin  = bin_q;
    next_wrap = 1'b0;
    if (load) begin
      next_bin = load_val;
    end else if (en) begin
      if (dir) begin
        next_bin  = bin_q + 1'b1;
        next_wrap = (bin_q == MAX_BIN);
      end else begin
        next_bin  = bin_q - 1'b1;
        next_wrap = (bin_q == '0);
      end
    end
  end

  b2g #(.WIDTH(WIDTH)) u_b2g (
    .bin  (next_bin),
    .gray (next_gray)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= INIT_BIN;
      gray_q <= INIT_GRAY;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= next_bin;
      gray_q <= next_gray;
      wrap_q <= next_wrap;
    end
  end

  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: 4-bit directed + random run and an 8-bit INIT=200 sweep.
module tb_gray_counter;
  import gray_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-bit instance, INIT = 0
  logic       rst4 = 1'b1, en4 = 1'b0, dir4 = 1'b0, load4 = 1'b0;
  logic [3:0] lv4 = '0;
  logic [3:0] bin4, gray4;
  logic       wrap4;

  gray_counter #(.WIDTH(4), .INIT(0)) dut4 (
    .clk(clk), .rst(rst4), .en(en4), .dir(dir4), .load(load4),
    .load_val(lv4), .bin_out(bin4), .gray_out(gray4), .wrap(wrap4)
  );

  // 8-bit instance, INIT = 200
  logic       rst8 = 1'b1, en8 = 1'b0, dir8 = 1'b1, load8 = 1'b0;
  logic [7:0] lv8 = '0;
  logic [7:0] bin8, gray8;
  logic       wrap8;

  gray_counter #(.WIDTH(8), .INIT(200)) dut8 (
    .clk(clk), .rst(rst8), .en(en8), .dir(dir8), .load(load8),
    .load_val(lv8), .bin_out(bin8), .gray_out(gray8), .wrap(wrap8)
  );

  int checks   = 0;
  int failures = 0;

  // reference state: plain integer count modulo 2**W
  int m4 = 0;
  int m8 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver + model for the 4-bit instance ----------------
  task automatic step4(input bit r, input bit l, input bit e, input bit d, input int v);
    logic [3:0] pg;
    bit         w;
    pg    = gray4;
    rst4  = r;
    load4 = l;
    en4   = e;
    dir4  = d;
    lv4   = v[3:0];
    @(posedge clk);
    #1;
    w = 1'b0;
    if (r) m4 = 0;
    else if (l) m4 = v % 16;
    else if (e && d) begin w = (m4 == 15); m4 = (m4 + 1) % 16; end
    else if (e) begin w = (m4 == 0); m4 = (m4 + 15) % 16; end
    check("bin4", 32'(bin4), 32'(m4));
    check("gray4", 32'(gray4), 32'(m4 ^ (m4 >> 1)));
    check("wrap4", 32'(wrap4), 32'(w));
    check("g2b4", 32'(gray2bin(16'(gray4))), 32'(m4));
    if (!r && !l && e) check("onebit4", 32'($countones(pg ^ gray4)), 32'd1);
  endtask

  int wraps8   = 0;
  int wrap_at8 = -1;

  initial begin
    logic [7:0] pg8;
    bit         w8;

    // Test 1: reset then 16 up steps
    step4(1, 0, 0, 0, 0);
    step4(1, 0, 0, 0, 0);
    check("rst_bin", 32'(bin4), 32'd0);
    check("rst_wrap", 32'(wrap4), 32'd0);
    for (int i = 0; i < 16; i++) step4(0, 0, 1, 1, 0);
    check("upwrap_gray", 32'(gray4), 32'd0);
    check("upwrap_pulse", 32'(wrap4), 32'd1);

    // Test 2: down wrap
    step4(0, 1, 0, 0, 0);
    step4(0, 0, 1, 0, 0);
    check("dnwrap_bin", 32'(bin4), 32'd15);
    check("dnwrap_gray", 32'(gray4), 32'b1000);
    check("dnwrap_pulse", 32'(wrap4), 32'd1);
    step4(0, 0, 1, 0, 0);
    check("dn14_gray", 32'(gray4), 32'b1001);
    check("dn14_wrap", 32'(wrap4), 32'd0);

    // Test 3: direction reversal around 5
    step4(0, 1, 0, 0, 5);
    step4(0, 0, 1, 1, 0);
    check("rev1_gray", 32'(gray4), 32'b0101);
    step4(0, 0, 1, 0, 0);
    check("rev2_gray", 32'(gray4), 32'b0111);
    step4(0, 0, 1, 1, 0);
    check("rev3_gray", 32'(gray4), 32'b0101);

    // Test 4: priority load > en, rst > load
    step4(0, 1, 1, 1, 9);
    check("prio_load_bin", 32'(bin4), 32'd9);
    check("prio_load_gray", 32'(gray4), 32'b1101);
    step4(1, 1, 1, 1, 9);
    check("prio_rst_bin", 32'(bin4), 32'd0);

    // Test 5: count to 12, hold, reset mid-count, resume
    for (int i = 0; i < 12; i++) step4(0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) step4(0, 0, 0, 1, 0);
    check("hold_gray", 32'(gray4), 32'b1010);
    step4(1, 0, 1, 1, 0);
    step4(0, 0, 1, 1, 0);
    check("resume_bin", 32'(bin4), 32'd1);

    // Random mix of rst/load/en/dir against the model
    for (int i = 0; i < 250; i++) begin
      step4(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 15));
    end

    // Test 6: 8-bit sweep from INIT=200
    rst8 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    m8 = 200;
    check("rst8_bin", 32'(bin8), 32'd200);
    rst8 = 1'b0;
    en8  = 1'b1;
    dir8 = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      pg8 = gray8;
      @(posedge clk); #1;
      w8 = (m8 == 255);
      m8 = (m8 + 1) % 256;
      if (wrap8) begin wraps8++; wrap_at8 = i; end
      check("bin8", 32'(bin8), 32'(m8));
      check("gray8", 32'(gray8), 32'(m8 ^ (m8 >> 1)));
      check("wrap8", 32'(wrap8), 32'(w8));
      check("onebit8", 32'($countones(pg8 ^ gray8)), 32'd1);
    end
    check("wraps8_count", 32'(wraps8), 32'd1);
    check("wraps8_cycle", 32'(wrap_at8), 32'd56);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
